// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// ----------------------------------------------------------------------------
// Serial pattern transmitter. A parallel word is accepted over a valid/ready
// load interface and shifted out MSB-first, one bit per clock, over a
// programmable length. A fixed idle gap is inserted after each frame and the
// shifting can be paused with HOLD. Intended to drive the serial input of the
// Mealy sequence detectors, in-system or as a bench stimulus source.
//
// Optional feature (compile-time macro SEQ_PATTERN_TX_PARITY_EN):
//   when defined, an even-parity bit (XOR of the L data bits sent) follows
//   the last data bit, is held by HOLD like data, and DONE moves to the cycle
//   after the parity bit. When undefined the frame is exactly L bits.
//
// Parameters:
//   WIDTH       maximum frame length in bits (2..32)
//   GAP_CYCLES  idle cycles inserted after each frame (0..15)
//   IDLE_LEVEL  value driven on OUT when no frame bit is being sent
//
// Ports:
//   CLOCK       in   system clock, all logic on the rising edge
//   RESET       in   synchronous reset, active-low
//   LOAD_VALID  in   frame request valid
//   LOAD_READY  out  block can accept a frame (only in IDLE)
//   LOAD_DATA   in   frame bits; bit L-1 is sent first
//   LOAD_LEN    in   bits to send; 0 or >WIDTH selects WIDTH
//   HOLD        in   pause shifting while high (no effect outside a frame)
//   OUT         out  serial data (registered)
//   OUT_VALID   out  OUT carries a frame bit (registered)
//   BUSY        out  block is not idle
//   DONE        out  one-cycle pulse on the first cycle after the frame
// ----------------------------------------------------------------------------
module seq_pattern_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       LOAD_VALID,
    output logic                       LOAD_READY,
    input  logic [WIDTH-1:0]           LOAD_DATA,
    input  logic [$clog2(WIDTH+1)-1:0] LOAD_LEN,
    input  logic                       HOLD,
    output logic                       OUT,
    output logic                       OUT_VALID,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int unsigned LenW = $clog2(WIDTH + 1);
    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam int unsigned GapW = 4;

    // The gap counter counts down to zero, so it is loaded with one less than
    // the number of gap cycles. Only used when GAP_CYCLES > 0.
    localparam logic [GapW-1:0] GapLast =
        (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StGap, StParity} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [IdxW-1:0]   idx_q,   idx_d;    // index of the bit currently on OUT
    logic [GapW-1:0]   gap_q,   gap_d;
    logic              out_q,   out_d;
    logic              ov_q,    ov_d;
    logic              done_q,  done_d;
    // Low for the cycle following any reset edge so LOAD_READY only rises
    // after the first edge with RESET released.
    logic              ren_q,   ren_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic              par_q,   par_d;
    logic [WIDTH-1:0]  len_mask;
`endif

    logic [LenW-1:0]   len_eff;
    logic [IdxW-1:0]   first_idx;
    logic              accept;
    logic              frame_end;

    // Effective length: out-of-range requests fall back to a full-width frame.
    always_comb begin
        if (LOAD_LEN == '0 || 32'(LOAD_LEN) > WIDTH) begin
            len_eff = LenW'(WIDTH);
        end else begin
            len_eff = LOAD_LEN;
        end
        first_idx = IdxW'(len_eff - LenW'(1));
    end

`ifdef SEQ_PATTERN_TX_PARITY_EN
    // Selects the L low bits that will actually be sent, for the parity bit.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            len_mask[i] = (i < int'(len_eff));
        end
    end
`endif

    assign LOAD_READY = (state_q == StIdle) && ren_q;
    assign accept     = LOAD_VALID && LOAD_READY;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        out_d     = out_q;
        ov_d      = ov_q;
        done_d    = 1'b0;
        ren_d     = 1'b1;
        frame_end = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
        par_d     = par_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d  = LOAD_DATA;
                    idx_d   = first_idx;
                    out_d   = LOAD_DATA[first_idx];
                    ov_d    = 1'b1;
                    state_d = StShift;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    par_d   = ^(LOAD_DATA & len_mask);
`endif
                end
            end

            StShift: begin
                if (!HOLD) begin
                    if (idx_q == '0) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        state_d = StParity;
                        out_d   = par_q;
                        ov_d    = 1'b1;
`else
                        frame_end = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q - IdxW'(1);
                        out_d = data_q[idx_q - IdxW'(1)];
                    end
                end
            end

`ifdef SEQ_PATTERN_TX_PARITY_EN
            StParity: begin
                if (!HOLD) begin
                    frame_end = 1'b1;
                end
            end
`endif

            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                out_d   = IDLE_LEVEL;
                ov_d    = 1'b0;
            end
        endcase

        // Last bit consumed: drop to the idle level, pulse DONE and either
        // insert the gap or become ready again straight away.
        if (frame_end) begin
            out_d  = IDLE_LEVEL;
            ov_d   = 1'b0;
            done_d = 1'b1;
            if (GAP_CYCLES > 0) begin
                state_d = StGap;
                gap_d   = GapLast;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= StIdle;
            data_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            out_q   <= IDLE_LEVEL;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
            ren_q   <= ren_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = ov_q;
    assign DONE      = done_q;
    assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx. Two instances share one stimulus stream: one with
// a single gap cycle and one with no gap. Each is tracked by a frame-level
// reference model (pending bit string + gap countdown) and checked every cycle.
module tb_seq_pattern_tx;

    localparam int unsigned W  = 8;
    localparam int unsigned LW = $clog2(W + 1);
    localparam bit          IdleLvl = 1'b0;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          LOAD_VALID;
    logic [W-1:0]  LOAD_DATA;
    logic [LW-1:0] LOAD_LEN;
    logic          HOLD;
    logic [1:0]    rdy, sout, sval, busy, done;

    seq_pattern_tx #(.WIDTH(W), .GAP_CYCLES(1), .IDLE_LEVEL(IdleLvl)) u_dut_g1 (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy[0]),
        .LOAD_DATA(LOAD_DATA), .LOAD_LEN(LOAD_LEN), .HOLD(HOLD),
        .OUT(sout[0]), .OUT_VALID(sval[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    seq_pattern_tx #(.WIDTH(W), .GAP_CYCLES(0), .IDLE_LEVEL(IdleLvl)) u_dut_g0 (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy[1]),
        .LOAD_DATA(LOAD_DATA), .LOAD_LEN(LOAD_LEN), .HOLD(HOLD),
        .OUT(sout[1]), .OUT_VALID(sval[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Reference model: bits still to be sent (current bit at index cnt-1).
    logic [W:0] m_bits [2];
    int         m_cnt  [2];
    int         m_gap  [2];
    bit         m_done [2];
    bit         m_ren  [2];
    bit         m_acc  [2];

    logic [31:0] cap;
    int          capn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int k);
        return (m_cnt[k] > 0) || (m_gap[k] > 0);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int  gcfg;
            bit  rdy_m;
            int  len;
            bit  par;
            gcfg      = (k == 0) ? 1 : 0;
            m_acc[k]  = 1'b0;
            if (!RESET) begin
                m_cnt[k]  = 0;
                m_gap[k]  = 0;
                m_done[k] = 1'b0;
                m_ren[k]  = 1'b0;
            end else begin
                rdy_m     = !m_busy(k) && m_ren[k];
                m_done[k] = 1'b0;
                if (m_cnt[k] > 0) begin
                    if (!HOLD) begin
                        m_cnt[k]--;
                        if (m_cnt[k] == 0) begin
                            m_done[k] = 1'b1;
                            m_gap[k]  = gcfg;
                        end
                    end
                end else if (m_gap[k] > 0) begin
                    m_gap[k]--;
                end else if (rdy_m && LOAD_VALID) begin
                    len = (LOAD_LEN == 0 || LOAD_LEN > W) ? W : int'(LOAD_LEN);
                    m_bits[k] = '0;
                    par = 1'b0;
                    for (int i = 0; i < len; i++) begin
                        m_bits[k][i] = LOAD_DATA[i];
                        par ^= LOAD_DATA[i];
                    end
                    m_cnt[k] = len;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    m_bits[k] = (m_bits[k] << 1) | {{W{1'b0}}, par};
                    m_cnt[k]  = len + 1;
`endif
                    m_acc[k] = 1'b1;
                end
                m_ren[k] = 1'b1;
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            string s;
            bit    ev;
            bit    eo;
            s  = (k == 0) ? "gap1" : "gap0";
            ev = (m_cnt[k] > 0);
            eo = ev ? m_bits[k][m_cnt[k] - 1] : IdleLvl;
            check_eq({s, ".out"},       32'(sout[k]), 32'(eo));
            check_eq({s, ".out_valid"}, 32'(sval[k]), 32'(ev));
            check_eq({s, ".busy"},      32'(busy[k]), 32'(m_busy(k)));
            check_eq({s, ".done"},      32'(done[k]), 32'(m_done[k]));
            check_eq({s, ".ready"},     32'(rdy[k]),  32'(!m_busy(k) && m_ren[k]));
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_step();
        @(negedge CLOCK);
        compare();
        if (sval[0]) begin
            cap = {cap[30:0], sout[0]};
            capn++;
        end
    endtask

    // Present a frame, wait for the gap-1 instance to take it, then drain.
    task automatic send_frame(input logic [W-1:0] data, input logic [LW-1:0] len,
                              input logic [31:0] hold_mask);
        int n;
        LOAD_DATA  = data;
        LOAD_LEN   = len;
        LOAD_VALID = 1'b1;
        HOLD       = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc[0] && n < 200);
        if (!m_acc[0]) check_eq("accept_timeout", 0, 1);
        LOAD_VALID = 1'b0;
        n = 0;
        while ((m_busy(0) || m_busy(1)) && n < 300) begin
            HOLD = (n < 32) ? hold_mask[n] : 1'b0;
            // Requests while both are mid-frame must be ignored.
            if (m_cnt[0] > 0 && m_cnt[1] > 0) begin
                LOAD_VALID = 1'($urandom_range(0, 1));
                LOAD_DATA  = W'($urandom);
            end else begin
                LOAD_VALID = 1'b0;
            end
            tick();
            n++;
        end
        if (m_busy(0) || m_busy(1)) check_eq("drain_timeout", 0, 1);
        HOLD       = 1'b0;
        LOAD_VALID = 1'b0;
    endtask

    initial begin
        int  n;
        bit  prev_done;
        RESET      = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_DATA  = '0;
        LOAD_LEN   = '0;
        HOLD       = 1'b0;
        cap        = '0;
        capn       = 0;
        for (int i = 0; i < 3; i++) tick();
        RESET = 1'b1;
        tick();

        // Basic frame, explicit stream check.
        cap  = '0;
        capn = 0;
        send_frame(8'b10011011, 4'd8, 32'h0);
`ifdef SEQ_PATTERN_TX_PARITY_EN
        check_eq("tp1_stream", cap, 32'b100110111);
        check_eq("tp1_nbits", 32'(capn), 32'd9);
`else
        check_eq("tp1_stream", cap, 32'b10011011);
        check_eq("tp1_nbits", 32'(capn), 32'd8);
`endif

        // Length clamping.
        send_frame(8'hA5, 4'd3, 32'h0);
        send_frame(8'hA5, 4'd0, 32'h0);
        send_frame(8'hA5, 4'd9, 32'h0);
`ifdef SEQ_PATTERN_TX_PARITY_EN
        send_frame(8'h03, 4'd2, 32'h0);
`endif

        // Hold for three cycles while bit 2 is on the line.
        send_frame(8'hF0, 4'd8, 32'hE);

        // Reset while bit 4 of 8'hFF is on the line.
        LOAD_DATA  = 8'hFF;
        LOAD_LEN   = 4'd8;
        LOAD_VALID = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc[0] && n < 50);
        LOAD_VALID = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        RESET = 1'b0;
        tick();
        check_eq("abort_busy", 32'(busy[0]), 32'd0);
        RESET = 1'b1;
        tick();
        send_frame(8'h5A, 4'd8, 32'h0);

        // Back-to-back loads with LOAD_VALID held; the no-gap instance must
        // take the second word in its DONE cycle.
        LOAD_DATA  = 8'h81;
        LOAD_LEN   = 4'd8;
        LOAD_VALID = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc[1] && n < 50);
        LOAD_DATA = 8'h7E;
        n = 0;
        do begin
            prev_done = done[1];
            tick();
            n++;
        end while (!m_acc[1] && n < 50);
        check_eq("b2b_accept_in_done", 32'(prev_done), 32'd1);
        n = 0;
        while (!m_acc[0] && n < 50) begin
            tick();
            n++;
        end
        LOAD_VALID = 1'b0;
        n = 0;
        while ((m_busy(0) || m_busy(1)) && n < 100) begin
            tick();
            n++;
        end

        // Randomized frames, lengths, holds and idle spacing.
        for (int t = 0; t < 40; t++) begin
            int idle;
            idle = int'($urandom_range(0, 3));
            for (int i = 0; i < idle; i++) tick();
            send_frame(W'($urandom), LW'($urandom_range(0, 15)), $urandom & $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
